dropout_accumulator: RTL and testbench

DROPOUT_ACCUMULATOR -- requirements
Module: dropout_accumulator

---
 rtl/dropout_accumulator.sv | 104 ++++++++++
 tb/tb_dropout_accumulator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dropout_accumulator.sv
// Dropout accumulator: per-neuron activity counts over a fixed sample window,
// registered fire mask and total activity presented with a valid/ready handshake.
module dropout_accumulator #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [CNT_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_fire,
    output logic [7:0]       out_total
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt      [8];
    logic [CNT_W-1:0] cnt_next [8];
    logic [CNT_W-1:0] samples;
    logic             accept;
    logic             last_sample;
    logic             release_result;
    logic [7:0]       fire_next;
    logic [7:0]       total_next;

    assign accept         = in_valid && in_ready;
    assign last_sample    = accept && (samples == LAST);
    assign release_result = (state == HOLD) && out_ready;

    // Fire and total are judged on the counts including the sample being accepted.
    always_comb begin
        total_next = '0;
        fire_next  = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_next[i]  = cnt[i] + CNT_W'(in_data[i]);
            fire_next[i] = (cnt_next[i] >= threshold);
            total_next   = total_next + 8'(cnt_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM: if (last_sample) state_next = HOLD;
                HOLD:  if (out_ready) state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    // Clear outranks both the accept and the result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            samples   <= '0;
            out_fire  <= '0;
            out_total <= '0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            samples   <= '0;
            out_fire  <= '0;
            out_total <= '0;
        end else if (release_result) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            samples <= '0;
        end else if (accept) begin
            for (int i = 0; i < 8; i++) cnt[i] <= cnt_next[i];
            samples <= samples + 1'b1;
            if (last_sample) begin
                out_fire  <= fire_next;
                out_total <= total_next;
            end
        end
    end

endmodule

// File: tb/tb_dropout_accumulator.sv
// Scoreboard bench for dropout_accumulator: directed windows plus random
// traffic checked against a popcount-based window model.
module tb_dropout_accumulator;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] threshold;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_fire;
    logic [7:0] out_total;

    always #5 clk = ~clk;

    dropout_accumulator #(.WINDOW(WIN), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
        .out_fire(out_fire), .out_total(out_total)
    );

    typedef struct {
        logic [7:0] fire;
        logic [7:0] total;
    } res_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    res_t       sb[$];
    logic [7:0] win[$];
    bit         m_hold   = 0;
    bit         prev_clr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_result(input int thr);
        res_t r;
        r.fire  = '0;
        r.total = '0;
        for (int n = 0; n < 8; n++) begin
            int count = 0;
            foreach (win[k]) count += int'(win[k][n]);
            r.fire[n] = (count >= thr);
            r.total  += 8'(count);
        end
        return r;
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input logic [4:0] thr,
                        input bit clr, input bit ordy);
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(!m_hold));
        chk("out_valid", int'(out_valid), int'(m_hold));
        if (prev_clr) begin
            chk("clear_fire", int'(out_fire), 0);
            chk("clear_total", int'(out_total), 0);
        end
        in_valid  = v;
        in_data   = d;
        threshold = thr;
        clear     = clr;
        out_ready = ordy;
        prev_clr  = clr;
        if (clr) begin
            win.delete();
            m_hold = 0;
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 0;
                win.delete();
            end
        end else if (v) begin
            win.push_back(d);
            if (win.size() == WIN) begin
                sb.push_back(ref_result(int'(thr)));
                m_hold = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0;
        clear    = 0;
        #2 reset = 1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_fire", int'(out_fire), 0);
        chk("rst_out_total", int'(out_total), 0);
        win.delete();
        sb.delete();
        m_hold   = 0;
        prev_clr = 0;
        @(negedge clk);
        #2 reset = 0;
    endtask

    task automatic window(input logic [7:0] d, input logic [4:0] thr, input bit rnd);
        for (int i = 0; i < WIN; i++) step(1, rnd ? 8'($urandom) : d, thr, 0, 0);
        step(0, 8'h00, thr, 0, 1);
    endtask

    res_t cur;
    bit   prev_v = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 0;
        end else begin
            if (out_valid && !prev_v) begin
                chk("result_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    chk("out_fire", int'(out_fire), int'(cur.fire));
                    chk("out_total", int'(out_total), int'(cur.total));
                end
            end else if (out_valid) begin
                chk("hold_fire", int'(out_fire), int'(cur.fire));
                chk("hold_total", int'(out_total), int'(cur.total));
            end
            prev_v = out_valid;
        end
    end

    initial begin
        reset = 1; clear = 0; in_valid = 0; in_data = 0;
        threshold = 0; out_ready = 0;
        #22 reset = 0;
        #1;
        chk("init_in_ready", int'(in_ready), 1);
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_out_fire", int'(out_fire), 0);
        chk("init_out_total", int'(out_total), 0);

        // 0x0F window, then a long stall with in_valid asserted in HOLD
        for (int i = 0; i < WIN; i++) step(1, 8'h0F, 5'd8, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 5'd8, 0, 0);
        step(0, 8'h00, 5'd8, 0, 1);
        step(0, 8'h00, 5'd8, 0, 0);

        // valid every other cycle, full activity
        for (int i = 0; i < 2 * WIN; i++) step(i[0], 8'hFF, 5'd16, 0, 0);
        step(0, 8'h00, 5'd16, 0, 1);

        // clear on the 10th sample
        for (int i = 0; i < 9; i++) step(1, 8'h55, 5'd16, 0, 0);
        step(1, 8'h55, 5'd16, 1, 0);
        window(8'h01, 5'd16, 0);

        // async reset after 5 accepts
        for (int i = 0; i < 5; i++) step(1, 8'hA5, 5'd3, 0, 0);
        do_reset();
        window(8'h3C, 5'd4, 1);

        // threshold corners
        window(8'h00, 5'd0, 1);
        window(8'h00, 5'd0, 0);
        window(8'h00, 5'd17, 1);
        window(8'hFF, 5'd17, 0);
        window(8'hFF, 5'd16, 0);

        // clear while a result is pending
        for (int i = 0; i < WIN; i++) step(1, 8'h81, 5'd1, 0, 0);
        step(1, 8'h00, 5'd1, 1, 1);
        step(0, 8'h00, 5'd1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step($urandom_range(0, 3) != 0, 8'($urandom), 5'($urandom_range(0, 20)),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0);
        end

        for (int i = 0; i < 3; i++) step(0, 8'h00, 5'd0, 0, 1);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
